// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic PE.
// Default widths, FSM state enum, saturation limit function.
package systolic_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 40;
  localparam int LIM_W      = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } pe_state_e;

  // Max (hi=1) or min (hi=0) value of a w-bit word.
  function automatic logic [LIM_W-1:0] sat_limit(
    input int   w,
    input logic sgn,
    input logic hi
  );
    logic [LIM_W-1:0] r;
    r = '0;
    for (int i = 0; i < LIM_W; i++) begin
      if (!sgn) begin
        r[i] = hi && (i < w);
      end else if (hi) begin
        r[i] = (i < w - 1);
      end else begin
        r[i] = (i == w - 1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Combinational extend-multiply-add-saturate for the PE.
// a,b operands; acc_in running sum; first zeroes acc_in; sum,ovf out.
module pe_mac
  import systolic_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              first,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam int PW = 2 * DATA_W;
  localparam logic SG = (SIGNED != 0);
  localparam logic ST = (SATURATE != 0);

  logic [PW-1:0]    a_x;
  logic [PW-1:0]    b_x;
  logic [PW-1:0]    prod;
  logic [ACC_W:0]   prod_x;
  logic [ACC_W:0]   acc_x;
  logic [ACC_W:0]   sum_x;
  logic [LIM_W-1:0] lim_hi;
  logic [LIM_W-1:0] lim_lo;

  // Low PW bits of the product are correct for both
  // modes once operands are extended to PW bits.
  assign a_x  = {{DATA_W{SG & a[DATA_W-1]}}, a};
  assign b_x  = {{DATA_W{SG & b[DATA_W-1]}}, b};
  assign prod = a_x * b_x;

  assign prod_x = {{(ACC_W+1-PW){SG & prod[PW-1]}}, prod};
  assign acc_x  = first ? '0
                : {SG & acc_in[ACC_W-1], acc_in};
  assign sum_x  = acc_x + prod_x;

  assign lim_hi = sat_limit(ACC_W, SG, 1'b1);
  assign lim_lo = sat_limit(ACC_W, SG, 1'b0);

  always_comb begin
    ovf = SG ? (sum_x[ACC_W] ^ sum_x[ACC_W-1])
             : sum_x[ACC_W];
    sum = sum_x[ACC_W-1:0];
    if (ovf && ST) begin
      // Signed: the extra top bit is the true sign.
      if (SG && sum_x[ACC_W]) sum = lim_lo[ACC_W-1:0];
      else                    sum = lim_hi[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/systolic_pe_v2.sv
// Output-stationary systolic MAC PE with framing and result buffer.
// west/north in, east/south forwarded, result valid/ready, sticky flags.
module systolic_pe_v2
  import systolic_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] west_data,
  input  logic              west_valid,
  input  logic              west_last,
  input  logic [DATA_W-1:0] north_data,
  input  logic              north_valid,
  output logic [DATA_W-1:0] east_data,
  output logic              east_valid,
  output logic              east_last,
  output logic [DATA_W-1:0] south_data,
  output logic              south_valid,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  input  logic              clear_flags,
  output logic              err_skew,
  output logic              err_overrun,
  output logic              sat_flag
);

  pe_state_e        state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic             ovf;
  logic             fire;
  logic             skew;
  logic             done;
  logic             take;

  assign fire = west_valid & north_valid;
  assign skew = west_valid ^ north_valid;
  assign done = fire & west_last;
  assign take = ~result_valid | result_ready;

  pe_mac #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .SIGNED  (SIGNED),
    .SATURATE(SATURATE)
  ) u_mac (
    .a     (west_data),
    .b     (north_data),
    .acc_in(acc),
    .first (state == IDLE),
    .sum   (sum),
    .ovf   (ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      east_data   <= '0;
      east_valid  <= 1'b0;
      east_last   <= 1'b0;
      south_data  <= '0;
      south_valid <= 1'b0;
    end else begin
      east_data   <= west_data;
      east_valid  <= west_valid;
      east_last   <= west_last;
      south_data  <= north_data;
      south_valid <= north_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
    end else if (fire) begin
      if (west_last) begin
        state <= IDLE;
        acc   <= '0;
      end else begin
        state <= ACCUM;
        acc   <= sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else if (done && take) begin
      result       <= sum;
      result_valid <= 1'b1;
    end else if (!done && result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

  // A set event beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_skew    <= 1'b0;
      err_overrun <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      err_skew    <= skew
                   | (err_skew & ~clear_flags);
      err_overrun <= (done & ~take)
                   | (err_overrun & ~clear_flags);
      sat_flag    <= (fire & ovf)
                   | (sat_flag & ~clear_flags);
    end
  end

endmodule

// File: tb/tb_systolic_pe_v2.sv
// Directed self-checking bench for systolic_pe_v2.
// Four parameter variants share one stimulus bus.
module tb_systolic_pe_v2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] wd = '0;
  logic        wv = 1'b0;
  logic        wl = 1'b0;
  logic [15:0] nd = '0;
  logic        nv = 1'b0;
  logic        rdy = 1'b1;
  logic        clr = 1'b0;

  logic [15:0] ed [4];
  logic [15:0] sd [4];
  logic        ev [4];
  logic        el [4];
  logic        sv [4];
  logic        rv [4];
  logic        es [4];
  logic        eo [4];
  logic        sf [4];

  logic [39:0] r_def;
  logic [39:0] r_sgn;
  logic [31:0] r_sat;
  logic [31:0] r_wrp;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  systolic_pe_v2 #(
    .DATA_W(16), .ACC_W(40), .SIGNED(0), .SATURATE(0)
  ) u_def (
    .clk(clk), .rst(rst),
    .west_data(wd), .west_valid(wv), .west_last(wl),
    .north_data(nd), .north_valid(nv),
    .east_data(ed[0]), .east_valid(ev[0]),
    .east_last(el[0]),
    .south_data(sd[0]), .south_valid(sv[0]),
    .result(r_def), .result_valid(rv[0]),
    .result_ready(rdy), .clear_flags(clr),
    .err_skew(es[0]), .err_overrun(eo[0]),
    .sat_flag(sf[0])
  );

  systolic_pe_v2 #(
    .DATA_W(16), .ACC_W(40), .SIGNED(1), .SATURATE(0)
  ) u_sgn (
    .clk(clk), .rst(rst),
    .west_data(wd), .west_valid(wv), .west_last(wl),
    .north_data(nd), .north_valid(nv),
    .east_data(ed[1]), .east_valid(ev[1]),
    .east_last(el[1]),
    .south_data(sd[1]), .south_valid(sv[1]),
    .result(r_sgn), .result_valid(rv[1]),
    .result_ready(rdy), .clear_flags(clr),
    .err_skew(es[1]), .err_overrun(eo[1]),
    .sat_flag(sf[1])
  );

  systolic_pe_v2 #(
    .DATA_W(16), .ACC_W(32), .SIGNED(0), .SATURATE(1)
  ) u_sat (
    .clk(clk), .rst(rst),
    .west_data(wd), .west_valid(wv), .west_last(wl),
    .north_data(nd), .north_valid(nv),
    .east_data(ed[2]), .east_valid(ev[2]),
    .east_last(el[2]),
    .south_data(sd[2]), .south_valid(sv[2]),
    .result(r_sat), .result_valid(rv[2]),
    .result_ready(rdy), .clear_flags(clr),
    .err_skew(es[2]), .err_overrun(eo[2]),
    .sat_flag(sf[2])
  );

  systolic_pe_v2 #(
    .DATA_W(16), .ACC_W(32), .SIGNED(0), .SATURATE(0)
  ) u_wrp (
    .clk(clk), .rst(rst),
    .west_data(wd), .west_valid(wv), .west_last(wl),
    .north_data(nd), .north_valid(nv),
    .east_data(ed[3]), .east_valid(ev[3]),
    .east_last(el[3]),
    .south_data(sd[3]), .south_valid(sv[3]),
    .result(r_wrp), .result_valid(rv[3]),
    .result_ready(rdy), .clear_flags(clr),
    .err_skew(es[3]), .err_overrun(eo[3]),
    .sat_flag(sf[3])
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(
    input logic [15:0] w,
    input logic [15:0] n,
    input logic        v_w,
    input logic        v_n,
    input logic        last
  );
    wd = w;
    nd = n;
    wv = v_w;
    nv = v_n;
    wl = last;
    @(posedge clk);
    #1;
    wv = 1'b0;
    nv = 1'b0;
    wl = 1'b0;
  endtask

  task automatic mac(
    input logic [15:0] w,
    input logic [15:0] n,
    input logic        last
  );
    beat(w, n, 1'b1, 1'b1, last);
  endtask

  task automatic idle();
    beat(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  task automatic clear_pulse();
    clr = 1'b1;
    idle();
    clr = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_valid", 64'(rv[0]), 64'd0);
    check("rst_result", 64'(r_def), 64'd0);
    check("rst_east_v", 64'(ev[0]), 64'd0);

    mac(16'd3, 16'd4, 1'b0);
    check("fwd_east", 64'(ed[0]), 64'd3);
    check("fwd_south", 64'(sd[0]), 64'd4);
    check("fwd_ev", 64'(ev[0]), 64'd1);
    check("fwd_sv", 64'(sv[0]), 64'd1);
    mac(16'd5, 16'd6, 1'b0);
    check("mid_valid", 64'(rv[0]), 64'd0);
    mac(16'd7, 16'd8, 1'b1);
    check("dot_valid", 64'(rv[0]), 64'd1);
    check("dot_result", 64'(r_def), 64'd98);
    check("fwd_el", 64'(el[0]), 64'd1);
    idle();
    check("fwd_ev_lo", 64'(ev[0]), 64'd0);
    check("consumed", 64'(rv[0]), 64'd0);
    check("res_hold", 64'(r_def), 64'd98);

    do_reset();
    mac(16'hFFFD, 16'd4, 1'b0);
    mac(16'd2, 16'hFFFB, 1'b1);
    check("sgn_result", 64'(r_sgn), 64'h00FF_FFFF_FFEA);
    check("sgn_valid", 64'(rv[1]), 64'd1);

    do_reset();
    mac(16'hFFFF, 16'hFFFF, 1'b0);
    mac(16'hFFFF, 16'hFFFF, 1'b0);
    mac(16'hFFFF, 16'hFFFF, 1'b1);
    check("sat_result", 64'(r_sat), 64'hFFFF_FFFF);
    check("sat_flag", 64'(sf[2]), 64'd1);
    check("wrp_result", 64'(r_wrp), 64'hFFFA_0003);
    check("wrp_flag", 64'(sf[3]), 64'd1);
    check("wide_result", 64'(r_def), 64'h2_FFFA_0003);
    check("wide_noflag", 64'(sf[0]), 64'd0);
    clear_pulse();
    check("sat_clear", 64'(sf[2]), 64'd0);

    do_reset();
    rdy = 1'b0;
    mac(16'd2, 16'd3, 1'b1);
    check("ovr_first", 64'(r_def), 64'd6);
    mac(16'd4, 16'd5, 1'b1);
    check("ovr_hold", 64'(r_def), 64'd6);
    check("ovr_flag", 64'(eo[0]), 64'd1);
    check("ovr_valid", 64'(rv[0]), 64'd1);
    rdy = 1'b1;
    idle();
    check("ovr_drain", 64'(rv[0]), 64'd0);
    clear_pulse();
    check("ovr_clear", 64'(eo[0]), 64'd0);
    rdy = 1'b0;
    mac(16'd2, 16'd3, 1'b1);
    check("bp_first", 64'(r_def), 64'd6);
    rdy = 1'b1;
    mac(16'd4, 16'd5, 1'b1);
    check("bp_second", 64'(r_def), 64'd20);
    check("bp_valid", 64'(rv[0]), 64'd1);
    check("bp_noerr", 64'(eo[0]), 64'd0);

    do_reset();
    mac(16'd1, 16'd1, 1'b0);
    mac(16'd2, 16'd2, 1'b0);
    beat(16'd5, 16'd0, 1'b1, 1'b0, 1'b0);
    check("skew_flag", 64'(es[0]), 64'd1);
    check("skew_nores", 64'(rv[0]), 64'd0);
    mac(16'd3, 16'd3, 1'b1);
    check("skew_result", 64'(r_def), 64'd14);
    clear_pulse();
    check("skew_clear", 64'(es[0]), 64'd0);
    clr = 1'b1;
    beat(16'd0, 16'd7, 1'b0, 1'b1, 1'b0);
    clr = 1'b0;
    check("set_wins", 64'(es[0]), 64'd1);

    do_reset();
    mac(16'd9, 16'd9, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("mid_rst_ed", 64'(ed[0]), 64'd0);
    check("mid_rst_sd", 64'(sd[0]), 64'd0);
    check("mid_rst_rv", 64'(rv[0]), 64'd0);
    check("mid_rst_res", 64'(r_def), 64'd0);
    check("mid_rst_es", 64'(es[0]), 64'd0);
    mac(16'd1, 16'd1, 1'b1);
    check("no_residue", 64'(r_def), 64'd1);
    check("no_res_v", 64'(rv[0]), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
